// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encodings, enable/flush bundles and the NOP used on flush.
package pipeline_hazard_controller_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int SQ_W = 2;
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SQUASH    = 2'd1,
    ST_LU_BUBBLE = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } hz_en_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
  } hz_flush_t;

  // Front end held, ID/EX takes a bubble, back end drains.
  function automatic hz_en_t en_front_stall();
    hz_en_t e;
    e.pc     = 1'b0;
    e.if_id  = 1'b0;
    e.id_ex  = 1'b1;
    e.ex_mem = 1'b1;
    e.mem_wb = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard inputs and stall/flush outputs of the hazard controller.
// master: the controller; slave: the pipeline datapath side.
interface pipeline_hazard_controller_if #(
  parameter int REG_ADDR_W =
    pipeline_hazard_controller_pkg::REG_ADDR_W,
  parameter int CNT_W = 32
);

  logic                  IMEM_BUSYWAIT;
  logic                  DMEM_BUSYWAIT;
  logic [REG_ADDR_W-1:0] ID_RS1;
  logic [REG_ADDR_W-1:0] ID_RS2;
  logic                  ID_USES_RS1;
  logic                  ID_USES_RS2;
  logic                  EX_MEM_READ;
  logic [REG_ADDR_W-1:0] EX_RD;
  logic                  BRANCH_TAKEN;
  logic                  PC_EN;
  logic                  IF_ID_EN;
  logic                  ID_EX_EN;
  logic                  EX_MEM_EN;
  logic                  MEM_WB_EN;
  logic                  IF_ID_FLUSH;
  logic                  ID_EX_FLUSH;
  logic [CNT_W-1:0]      STALL_COUNT;
  logic [CNT_W-1:0]      FLUSH_COUNT;

  modport master (
    input  IMEM_BUSYWAIT, DMEM_BUSYWAIT,
    input  ID_RS1, ID_RS2,
    input  ID_USES_RS1, ID_USES_RS2,
    input  EX_MEM_READ, EX_RD,
    input  BRANCH_TAKEN,
    output PC_EN, IF_ID_EN, ID_EX_EN,
    output EX_MEM_EN, MEM_WB_EN,
    output IF_ID_FLUSH, ID_EX_FLUSH,
    output STALL_COUNT, FLUSH_COUNT
  );

  modport slave (
    output IMEM_BUSYWAIT, DMEM_BUSYWAIT,
    output ID_RS1, ID_RS2,
    output ID_USES_RS1, ID_USES_RS2,
    output EX_MEM_READ, EX_RD,
    output BRANCH_TAKEN,
    input  PC_EN, IF_ID_EN, ID_EX_EN,
    input  EX_MEM_EN, MEM_WB_EN,
    input  IF_ID_FLUSH, ID_EX_FLUSH,
    input  STALL_COUNT, FLUSH_COUNT
  );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating event counter used for the stall/flush statistics.
// Sticks at all-ones instead of wrapping.
module hazard_sat_counter
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INC,
  output logic [CNT_W-1:0] COUNT
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (INC && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign COUNT = r_count;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: branch squash
// window, one-shot load-use bubble, cache waits and counters.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W =
    pipeline_hazard_controller_pkg::REG_ADDR_W,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 32
) (
  input logic CLK,
  input logic RESET,
  pipeline_hazard_controller_if.master bus
);

  import pipeline_hazard_controller_pkg::*;

  localparam logic [SQ_W-1:0] SQ_INIT =
    SQ_W'(FLUSH_CYCLES - 1);

  hz_state_e       r_state;
  hz_state_e       w_nxt;
  logic [SQ_W-1:0] r_sq;
  logic [SQ_W-1:0] w_sq_nxt;
  hz_en_t          w_en;
  hz_flush_t       w_fl;

  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [REG_ADDR_W-1:0] w_rd;
  logic                  w_hit1;
  logic                  w_hit2;
  logic                  w_lu;
  logic                  w_stall_inc;
  logic                  w_flush_inc;
  logic [CNT_W-1:0]      w_stall_cnt;
  logic [CNT_W-1:0]      w_flush_cnt;

  assign w_rs1  = bus.ID_RS1;
  assign w_rs2  = bus.ID_RS2;
  assign w_rd   = bus.EX_RD;
  assign w_hit1 = bus.ID_USES_RS1 && (w_rs1 == w_rd);
  assign w_hit2 = bus.ID_USES_RS2 && (w_rs2 == w_rd);
  assign w_lu   = bus.EX_MEM_READ && (w_rd != '0)
                && (w_hit1 || w_hit2);

  always_comb begin
    w_en     = '0;
    w_fl     = '0;
    w_nxt    = r_state;
    w_sq_nxt = r_sq;
    if (RESET) begin
      w_nxt    = ST_RUN;
      w_sq_nxt = '0;
    end else if (bus.DMEM_BUSYWAIT) begin
      // Global freeze: EX is held, so a taken branch re-presents.
      w_en = '0;
    end else if (bus.BRANCH_TAKEN) begin
      w_en     = '1;
      w_fl     = '1;
      w_nxt    = (FLUSH_CYCLES > 1) ? ST_SQUASH : ST_RUN;
      w_sq_nxt = (FLUSH_CYCLES > 1) ? SQ_INIT : '0;
    end else if (r_state == ST_SQUASH) begin
      w_en    = '1;
      w_en.pc = !bus.IMEM_BUSYWAIT;
      w_fl    = '1;
      if (!bus.IMEM_BUSYWAIT) begin
        w_sq_nxt = r_sq - SQ_W'(1);
        if (r_sq == SQ_W'(1)) begin
          w_nxt = ST_RUN;
        end
      end
    end else if (r_state == ST_RUN && w_lu) begin
      w_en       = en_front_stall();
      w_fl.id_ex = 1'b1;
      w_nxt      = ST_LU_BUBBLE;
    end else begin
      w_nxt = ST_RUN;
      if (bus.IMEM_BUSYWAIT) begin
        w_en       = en_front_stall();
        w_fl.id_ex = 1'b1;
      end else begin
        w_en = '1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_RUN;
      r_sq    <= '0;
    end else begin
      r_state <= w_nxt;
      r_sq    <= w_sq_nxt;
    end
  end

  assign bus.PC_EN       = w_en.pc;
  assign bus.IF_ID_EN    = w_en.if_id;
  assign bus.ID_EX_EN    = w_en.id_ex;
  assign bus.EX_MEM_EN   = w_en.ex_mem;
  assign bus.MEM_WB_EN   = w_en.mem_wb;
  assign bus.IF_ID_FLUSH = w_fl.if_id;
  assign bus.ID_EX_FLUSH = w_fl.id_ex;

  assign w_stall_inc = !RESET && !w_en.pc;
  assign w_flush_inc = w_fl.if_id;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (w_stall_inc),
    .COUNT (w_stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (w_flush_inc),
    .COUNT (w_flush_cnt)
  );

  assign bus.STALL_COUNT = w_stall_cnt;
  assign bus.FLUSH_COUNT = w_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two configurations driven
// in lockstep, compared each cycle against a rule-level model.
module tb_pipeline_hazard_controller;

  logic clk;
  logic rst;
  logic imem, dmem, br, mr, u1, u2;
  logic [4:0] rs1, rs2, rd;

  int vectors = 0;
  int miscompares = 0;

  pipeline_hazard_controller_if #(.REG_ADDR_W(5), .CNT_W(32)) ifa();
  pipeline_hazard_controller_if #(.REG_ADDR_W(5), .CNT_W(4))  ifb();

  assign ifa.IMEM_BUSYWAIT = imem;
  assign ifa.DMEM_BUSYWAIT = dmem;
  assign ifa.ID_RS1        = rs1;
  assign ifa.ID_RS2        = rs2;
  assign ifa.ID_USES_RS1   = u1;
  assign ifa.ID_USES_RS2   = u2;
  assign ifa.EX_MEM_READ   = mr;
  assign ifa.EX_RD         = rd;
  assign ifa.BRANCH_TAKEN  = br;
  assign ifb.IMEM_BUSYWAIT = imem;
  assign ifb.DMEM_BUSYWAIT = dmem;
  assign ifb.ID_RS1        = rs1;
  assign ifb.ID_RS2        = rs2;
  assign ifb.ID_USES_RS1   = u1;
  assign ifb.ID_USES_RS2   = u2;
  assign ifb.EX_MEM_READ   = mr;
  assign ifb.EX_RD         = rd;
  assign ifb.BRANCH_TAKEN  = br;

  pipeline_hazard_controller #(
    .REG_ADDR_W(5), .FLUSH_CYCLES(3), .CNT_W(32)
  ) dut_a (.CLK(clk), .RESET(rst), .bus(ifa));

  pipeline_hazard_controller #(
    .REG_ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(4)
  ) dut_b (.CLK(clk), .RESET(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: remaining squash cycles after a branch, whether the
  // one bubble for the current load was already spent, counters.
  int     fc[2]   = '{3, 2};
  longint cmax[2] = '{64'hFFFFFFFF, 64'd15};
  int     sq[2]   = '{0, 0};
  bit     bub[2]  = '{1'b0, 1'b0};
  longint st[2]   = '{0, 0};
  longint fl[2]   = '{0, 0};

  function automatic bit lu_hit();
    return mr && (rd != 5'd0) &&
      ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl}
  function automatic logic [6:0] exp_ctl(int k);
    if (rst)             return 7'b00000_00;
    if (dmem)            return 7'b00000_00;
    if (br)              return 7'b11111_11;
    if (sq[k] > 0)       return {!imem, 6'b1111_11};
    if (lu_hit() && !bub[k]) return 7'b00111_01;
    if (imem)            return 7'b00111_01;
    return 7'b11111_00;
  endfunction

  function automatic logic [6:0] obs_ctl(int k);
    if (k == 0)
      return {ifa.PC_EN, ifa.IF_ID_EN, ifa.ID_EX_EN,
              ifa.EX_MEM_EN, ifa.MEM_WB_EN,
              ifa.IF_ID_FLUSH, ifa.ID_EX_FLUSH};
    return {ifb.PC_EN, ifb.IF_ID_EN, ifb.ID_EX_EN,
            ifb.EX_MEM_EN, ifb.MEM_WB_EN,
            ifb.IF_ID_FLUSH, ifb.ID_EX_FLUSH};
  endfunction

  function automatic logic [63:0] obs_st(int k);
    return (k == 0) ? 64'(ifa.STALL_COUNT)
                    : 64'(ifb.STALL_COUNT);
  endfunction

  function automatic logic [63:0] obs_fl(int k);
    return (k == 0) ? 64'(ifa.FLUSH_COUNT)
                    : 64'(ifb.FLUSH_COUNT);
  endfunction

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_step(int k, logic [6:0] c);
    bit lu;
    lu = lu_hit();
    if (rst) begin
      sq[k] = 0; bub[k] = 0; st[k] = 0; fl[k] = 0;
      return;
    end
    if (!c[6] && st[k] < cmax[k]) st[k]++;
    if (c[1] && fl[k] < cmax[k]) fl[k]++;
    if (dmem) begin
    end else if (br) begin
      sq[k] = fc[k] - 1; bub[k] = 0;
    end else if (sq[k] > 0) begin
      if (!imem) sq[k]--;
    end else if (lu && !bub[k]) begin
      bub[k] = 1;
    end else begin
      bub[k] = 0;
    end
  endtask

  // Called at a negedge with inputs applied; leaves at next negedge.
  task automatic tick();
    logic [6:0] c[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      c[k] = exp_ctl(k);
      check(k == 0 ? "ctl_a" : "ctl_b", 64'(obs_ctl(k)),
            64'(c[k]));
      check(k == 0 ? "stall_a" : "stall_b", obs_st(k),
            64'(st[k]));
      check(k == 0 ? "flush_a" : "flush_b", obs_fl(k),
            64'(fl[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, c[k]);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; imem = 0; dmem = 0; br = 0; mr = 0;
    u1 = 0; u2 = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic set_lu();
    mr = 1; rd = 5'd5; rs1 = 5'd5; u1 = 1;
  endtask

  longint base_a, base_b;

  initial begin
    idle();
    rst = 1; br = 1;
    @(negedge clk);
    tick(); tick();
    idle();
    tick();

    set_lu();
    tick(); tick();
    idle();
    tick();
    check("lu_stall_a", obs_st(0), 64'd1);

    br = 1; tick();
    br = 0;
    repeat (4) tick();
    check("br_flush_a", obs_fl(0), 64'd3);
    check("br_flush_b", obs_fl(1), 64'd2);

    dmem = 1; br = 1; set_lu();
    repeat (4) tick();
    dmem = 0;
    tick();
    idle();
    repeat (3) tick();
    check("frz_stall_a", obs_st(0), 64'd5);

    base_a = fl[0]; base_b = fl[1];
    br = 1; tick();
    br = 0; imem = 1;
    repeat (3) tick();
    imem = 0;
    repeat (3) tick();
    check("sqimem_flush_b", obs_fl(1), 64'(base_b + 5));
    check("sqimem_flush_a", obs_fl(0), 64'(base_a + 6));

    imem = 1;
    repeat (20) tick();
    imem = 0;
    tick();
    check("sat_stall_b", obs_st(1), 64'd15);

    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom % 40) == 0;
      imem = ($urandom % 4) == 0;
      dmem = ($urandom % 6) == 0;
      br   = ($urandom % 5) == 0;
      mr   = $urandom % 2;
      u1   = $urandom % 2;
      u2   = $urandom % 2;
      rd   = 5'($urandom_range(0, 3));
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the per-register write enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Inputs are the instruction-cache and data-cache busywaits, the load-use hazard operands and the EX-stage branch-taken signal.
- Holds a small FSM for the branch squash window and the load-use bubble, plus saturating stall/flush performance counters.

Parameters:
- REG_ADDR_W, 5, register-index width.
- FLUSH_CYCLES, 1, number of cycles IF/ID and ID/EX are squashed after a taken branch (1..4).
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  system clock, all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- IMEM_BUSYWAIT  in  1  instruction cache not ready.
- DMEM_BUSYWAIT  in  1  data cache not ready.
- ID_RS1, ID_RS2  in  REG_ADDR_W  source registers of the instruction in ID.
- ID_USES_RS1, ID_USES_RS2  in  1  source actually read.
- EX_MEM_READ  in  1  instruction in EX is a load.
- EX_RD  in  REG_ADDR_W  destination of the instruction in EX.
- BRANCH_TAKEN  in  1  EX resolved a taken branch/jump.
- PC_EN  out  1  PC write enable.
- IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1  pipeline register write enables.
- IF_ID_FLUSH, ID_EX_FLUSH  out  1  load a NOP bubble at the next edge.
- STALL_COUNT  out  CNT_W  cycles with PC_EN=0 (excluding reset).
- FLUSH_COUNT  out  CNT_W  cycles with IF_ID_FLUSH=1.

Behaviour:
- Control outputs are combinational from registered FSM state and current inputs; they act at the next posedge.
- FSM state, squash counter and performance counters are registered.
- States:
  - RUN: normal operation.
  - SQUASH: remaining post-branch flush cycles.
  - LU_BUBBLE: one-cycle load-use stall already issued.
- RESET high at a posedge:
  - state <= RUN, squash counter <= 0, STALL_COUNT <= 0, FLUSH_COUNT <= 0.
  - While RESET is high, all EN=0 and all FLUSH=0.
  - RESET mid-squash or mid-bubble aborts immediately.
- Load-use hazard LU = EX_MEM_READ & (EX_RD!=0) & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
- Priority (highest first) in any state:
  1. DMEM_BUSYWAIT:
     - All EN=0, all FLUSH=0 (global freeze).
     - State and squash counter hold.
     - BRANCH_TAKEN is ignored this cycle; EX is frozen, so it is re-presented afterwards.
  2. BRANCH_TAKEN:
     - PC_EN=1 (target load, permitted even if IMEM_BUSYWAIT=1; the cache restarts on address change).
     - IF_ID_FLUSH=1, ID_EX_FLUSH=1, all other EN=1.
     - If FLUSH_CYCLES>1: state <= SQUASH, counter <= FLUSH_CYCLES-1; else state <= RUN.
  3. State SQUASH:
     - PC_EN=!IMEM_BUSYWAIT, IF_ID_FLUSH=1, ID_EX_FLUSH=1, EX_MEM_EN=MEM_WB_EN=1.
     - Counter decrements only when IMEM_BUSYWAIT=0; on reaching 0, state <= RUN.
  4. LU in RUN:
     - PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, EX_MEM_EN=MEM_WB_EN=1.
     - state <= LU_BUBBLE.
  5. State LU_BUBBLE:
     - Behaves as RUN, but LU is not re-evaluated; guarantees exactly one bubble per load.
     - state <= RUN.
  6. IMEM_BUSYWAIT:
     - PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, EX_MEM_EN=MEM_WB_EN=1.
  7. Otherwise: all EN=1, all FLUSH=0.
- Whenever a FLUSH is 1, the matching EN is also 1.
- Counters:
  - Increment by 1 per qualifying cycle.
  - Saturate at all-ones, no wrap.
  - Do not change during DMEM freeze for FLUSH_COUNT; STALL_COUNT does count freeze cycles.

Decomposition:
- Shared package holds:
  - state encodings (ST_RUN=2'd0, ST_SQUASH=2'd1, ST_LU_BUBBLE=2'd2);
  - REG_ADDR_W;
  - NOP encoding 32'h00000013, used by the pipeline registers on flush.
- One sub-module is natural: hazard_sat_counter (CNT_W parameter; inputs CLK, RESET, INC; output COUNT), instantiated twice.

Test Plan:
- RESET=1 for 2 edges with BRANCH_TAKEN=1 -> all EN=0, FLUSH=0, STALL_COUNT=0, FLUSH_COUNT=0, state RUN after release.
- EX_MEM_READ=1, EX_RD=5, ID_RS1=5, ID_USES_RS1=1, held 2 cycles -> cycle 1 PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1; cycle 2 all EN=1; STALL_COUNT=1.
- FLUSH_CYCLES=3, BRANCH_TAKEN pulse 1 cycle -> IF_ID_FLUSH=ID_EX_FLUSH=1 for 3 consecutive cycles, PC_EN=1 throughout, FLUSH_COUNT=3.
- DMEM_BUSYWAIT=1 for 4 cycles with BRANCH_TAKEN=1 and LU=1 -> all EN=0 for 4 cycles; on release, branch wins (flushes asserted, no load-use bubble); STALL_COUNT=4.
- IMEM_BUSYWAIT=1 for 3 cycles during SQUASH (FLUSH_CYCLES=2) -> squash extends to 1+3+1 cycles, PC_EN=0 while busy.
- CNT_W=4, IMEM_BUSYWAIT=1 for 20 cycles -> STALL_COUNT saturates at 15.
